adc_acq_scheduler: RTL

//  Sequences the ADC manager: paces conversion triggers at a programmable period,

---
 rtl/adc_acq_scheduler_if.sv | 30 +++
 rtl/adc_acq_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/adc_acq_scheduler_if.sv
// adc_acq_scheduler_if
//   Handshake bundle between the acquisition scheduler, the register-word
//   source, and the ADC manager.
//   cfg_*          : register-word stream into the scheduler FIFO
//   adc_ready      : manager idle and able to accept work
//   adc_cnv_done   : manager strobe, one conversion word handed off
//   adc_trigger    : conversion trigger pulse to the manager
//   adc_cfg_*      : register-word stream from the FIFO head to the manager
//   master modport : scheduler side; slave modport : source/manager side.
interface adc_acq_scheduler_if;
  logic [31:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic        adc_ready;
  logic        adc_cnv_done;
  logic        adc_trigger;
  logic [31:0] adc_cfg_tdata;
  logic        adc_cfg_tvalid;
  logic        adc_cfg_tready;

  modport master (
    input  cfg_tdata, cfg_tvalid, adc_ready, adc_cnv_done, adc_cfg_tready,
    output cfg_tready, adc_trigger, adc_cfg_tdata, adc_cfg_tvalid
  );

  modport slave (
    output cfg_tdata, cfg_tvalid, adc_ready, adc_cnv_done, adc_cfg_tready,
    input  cfg_tready, adc_trigger, adc_cfg_tdata, adc_cfg_tvalid
  );
endinterface

// File: rtl/adc_acq_scheduler.sv
// adc_acq_scheduler
//   Paces ADC conversion triggers at a programmable period, counts bursts and
//   shares the single ADC SPI resource between conversions and queued
//   register-write words.
// Ports
//   spi_clk, aresetn : clock (rising edge), async active-low reset
//   start            : 1-cycle run request, honoured only in IDLE
//   abort            : stop run, back to IDLE (highest priority)
//   period           : trigger spacing in cycles (<2 behaves as 2), sampled at start
//   burst_len        : triggers per run, 0 = continuous, sampled at start
//   bus              : adc_acq_scheduler_if.master (cfg stream, ADC manager handshake)
//   busy             : state != IDLE
//   done             : 1-cycle pulse when a finite burst has fully completed
//   overrun          : sticky, a tick found adc_ready low; cleared by start
// Build option
//   ADC_SCHED_EXT_TRIG_EN : adds async input ext_trig; its synchronised rising
//   edge acts as start in IDLE and replaces the period counter as tick source.
//
// state | meaning
// IDLE  | no run; FIFO words forwarded to the manager
// CFG   | run requested; draining FIFO before first trigger
// RUN   | pacing triggers; FIFO forwarding held off
// DRAIN | all triggers issued; waiting for the matching cnv_done strobes
module adc_acq_scheduler #(
  parameter int CNT_WIDTH   = 32,
  parameter int BURST_WIDTH = 16,
  parameter int CFG_DEPTH   = 4
) (
  input  logic                   spi_clk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_WIDTH-1:0]   period,
  input  logic [BURST_WIDTH-1:0] burst_len,
`ifdef ADC_SCHED_EXT_TRIG_EN
  input  logic                   ext_trig,
`endif
  adc_acq_scheduler_if.master    bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int AW = $clog2(CFG_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_RUN, S_DRAIN} state_t;

  state_t state_q, state_d;

  // register-word FIFO; pointers carry one extra wrap bit
  logic [31:0] mem_q [CFG_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full, push, pop, fwd_en;

  logic [CNT_WIDTH-1:0]   period_eff, period_q, cnt_q;
  logic [BURST_WIDTH-1:0] burst_q, issued_q, completed_q, completed_d;
  logic                   trig_q, done_q, overrun_q;

  logic start_ev, tick_src, burst_hit;
  logic accept_start, tick_run, trig_d, done_d, drop_tick;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fwd_en     = (state_q == S_IDLE) || (state_q == S_CFG);

  assign bus.cfg_tready     = !fifo_full;
  assign bus.adc_cfg_tvalid = fwd_en && !fifo_empty && bus.adc_ready;
  // memory is reset, so the head reads 0 out of reset
  assign bus.adc_cfg_tdata  = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.adc_trigger    = trig_q;

  assign push = bus.cfg_tvalid && bus.cfg_tready;
  assign pop  = bus.adc_cfg_tvalid && bus.adc_cfg_tready;

  always_ff @(posedge spi_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < CFG_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= bus.cfg_tdata;
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

`ifdef ADC_SCHED_EXT_TRIG_EN
  // [0],[1] synchroniser, [2] previous synchronised value for edge detect
  logic [2:0] ext_sync_q;
  logic       ext_rise;

  always_ff @(posedge spi_clk or negedge aresetn) begin
    if (!aresetn) ext_sync_q <= '0;
    else          ext_sync_q <= {ext_sync_q[1:0], ext_trig};
  end

  assign ext_rise = ext_sync_q[1] && !ext_sync_q[2];
  assign start_ev = start || ext_rise;
  assign tick_src = ext_rise;
`else
  assign start_ev = start;
  assign tick_src = (cnt_q == '0);
`endif

  assign period_eff  = (period < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : period;
  assign burst_hit   = (burst_q != '0) && (issued_q == burst_q);
  assign completed_d = completed_q + BURST_WIDTH'(bus.adc_cnv_done &&
                         ((state_q == S_RUN) || (state_q == S_DRAIN)));

  always_ff @(posedge spi_clk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    tick_run     = 1'b0;
    trig_d       = 1'b0;
    drop_tick    = 1'b0;
    done_d       = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ev) begin
            accept_start = 1'b1;
            state_d      = fifo_empty ? S_RUN : S_CFG;
          end
        end
        S_CFG: begin
          if (fifo_empty && bus.adc_ready) state_d = S_RUN;
        end
        S_RUN: begin
          if (burst_hit) begin
            state_d = S_DRAIN;
          end else if (tick_src) begin
            tick_run  = 1'b1;
            trig_d    = bus.adc_ready;
            drop_tick = !bus.adc_ready;
          end
        end
        S_DRAIN: begin
          // include this cycle's strobe so done follows the last cnv_done directly
          if (completed_d == issued_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge spi_clk or negedge aresetn) begin
    if (!aresetn) begin
      period_q    <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      trig_q <= trig_d;
      done_q <= done_d;
      if (accept_start) begin
        // counter is preloaded here and holds through CFG until RUN begins
        period_q    <= period_eff;
        burst_q     <= burst_len;
        cnt_q       <= period_eff - CNT_WIDTH'(1);
        issued_q    <= '0;
        completed_q <= '0;
        overrun_q   <= 1'b0;
      end else begin
        completed_q <= completed_d;
        if (tick_run)
          cnt_q <= period_q - CNT_WIDTH'(1);
        else if ((state_q == S_RUN) && !burst_hit && !abort)
          cnt_q <= cnt_q - CNT_WIDTH'(1);
        if (trig_d)    issued_q  <= issued_q + BURST_WIDTH'(1);
        if (drop_tick) overrun_q <= 1'b1;
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
